// File: rtl/bitonic_pkg.sv
// Shared types and sizing helpers for the iterative bitonic sort scheduler.
package bitonic_pkg;

  localparam int unsigned KEY_W     = 8;
  localparam int unsigned NUM_KEYS  = 8;
  localparam int unsigned KEY_IDX_W = 3;

  typedef logic [KEY_W-1:0] key_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of compare-exchange passes needed to sort 2**idx_w keys.
  function automatic int unsigned num_pass(input int unsigned idx_w);
    return (idx_w * (idx_w + 1)) / 2;
  endfunction

endpackage

// File: rtl/bitonic_cx_pass.sv
// One combinational bitonic compare-exchange pass over the whole key vector,
// selected at run time by stage p and partner distance d.
module bitonic_max_min #(
  parameter int unsigned width = 8
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic [width-1:0] max_o,
  output logic [width-1:0] min_o
);

  // Ties resolve with a as the max.
  assign max_o = (a_i >= b_i) ? a_i : b_i;
  assign min_o = (a_i >= b_i) ? b_i : a_i;

endmodule

module bitonic_cx_pass #(
  parameter int unsigned width       = 8,
  parameter int unsigned index       = 8,
  parameter int unsigned index_width = 3,
  parameter int unsigned cnt_w       = 2
) (
  input  logic [width-1:0] work_i [0:index-1],
  input  logic [cnt_w-1:0] p,
  input  logic [cnt_w-1:0] d,
  output logic [width-1:0] work_o [0:index-1]
);

  localparam int unsigned HALF = index / 2;

  logic [index_width-1:0] d_bit;
  logic [index_width-1:0] low_mask;
  logic [index_width-1:0] lo_idx [0:HALF-1];
  logic [index_width-1:0] hi_idx [0:HALF-1];
  logic [width-1:0]       mn     [0:HALF-1];
  logic [width-1:0]       mx     [0:HALF-1];
  logic                   desc   [0:HALF-1];

  assign d_bit    = index_width'(1) << d;
  assign low_mask = d_bit - index_width'(1);

  // Pair k: insert a zero at bit d of k to get the lower partner.
  for (genvar k = 0; k < HALF; k++) begin : g_pair
    localparam logic [index_width-1:0] KK = index_width'(k);

    assign lo_idx[k] = ((KK & ~low_mask) << 1) | (KK & low_mask);
    assign hi_idx[k] = lo_idx[k] | d_bit;
    // Shifting past the top index bit yields 0, so the final pass is all ascending.
    assign desc[k]   = ((lo_idx[k] >> p) & index_width'(1)) != '0;

    bitonic_max_min #(.width(width)) u_max_min (
      .a_i   (work_i[lo_idx[k]]),
      .b_i   (work_i[hi_idx[k]]),
      .max_o (mx[k]),
      .min_o (mn[k])
    );
  end

  always_comb begin
    work_o = work_i;
    for (int k = 0; k < HALF; k++) begin
      work_o[lo_idx[k]] = desc[k] ? mx[k] : mn[k];
      work_o[hi_idx[k]] = desc[k] ? mn[k] : mx[k];
    end
  end

endmodule

// File: rtl/bitonic_iter_sched.sv
// Iterative bitonic sorter: accepts a key vector, runs it through one shared
// compare-exchange pass per cycle, then holds the sorted vector for the consumer.
module bitonic_iter_sched
  import bitonic_pkg::*;
#(
  parameter int unsigned width       = KEY_W,
  parameter int unsigned index       = NUM_KEYS,
  parameter int unsigned index_width = KEY_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data  [0:index-1],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data [0:index-1],
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(index_width + 1);

  state_e           state_q, state_d;
  logic [width-1:0] work_q [0:index-1];
  logic [width-1:0] work_d [0:index-1];
  logic [width-1:0] pass_w [0:index-1];
  logic [CNT_W-1:0] p_q, p_d;
  logic [CNT_W-1:0] d_q, d_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             accept;

  bitonic_cx_pass #(
    .width       (width),
    .index       (index),
    .index_width (index_width),
    .cnt_w       (CNT_W)
  ) u_cx_pass (
    .work_i (work_q),
    .p      (p_q),
    .d      (d_q),
    .work_o (pass_w)
  );

  // A draining DONE cycle can take the next vector without a bubble.
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    p_d     = p_q;
    d_d     = d_q;
    unique case (state_q)
      IDLE: ;
      RUN: begin
        work_d = pass_w;
        if (d_q != '0) begin
          d_d = d_q - CNT_W'(1);
        end else if (p_q < CNT_W'(index_width)) begin
          p_d = p_q + CNT_W'(1);
          d_d = p_q;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = RUN;
      work_d  = in_data;
      p_d     = CNT_W'(1);
      d_d     = '0;
    end
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      p_q         <= CNT_W'(1);
      d_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < index; i++) work_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      work_q      <= work_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = work_q;

endmodule
